// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcode encoding, status flag
// layout and the flag value presented while in reset.
package alu_pkg;

  localparam int unsigned SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

  // out clears to zero in reset, so the zero flag must read 1 there
  localparam alu_flags_t FLAGS_RESET = '{carry: 1'b0, overflow: 1'b0, zero: 1'b1, negative: 1'b0};

  function automatic logic op_is_arith(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath of the ALU: opcode decode, WIDTH+1-bit
// adder/subtractor and logic mux producing next result, carry and overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow
);

  alu_op_e          op_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             carry_raw_s;
  logic             ovf_raw_s;

  assign op_s = alu_op_e'(sel);

  // Extra top bit yields the carry for ADD and the borrow (A < B) for SUB.
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
  end

  // Result select and raw arithmetic flags per opcode.
  always_comb begin
    res         = {WIDTH{1'b0}};
    carry_raw_s = 1'b0;
    ovf_raw_s   = 1'b0;
    case (op_s)
      OP_ADD: begin
        res         = sum_s[WIDTH-1:0];
        carry_raw_s = sum_s[WIDTH];
        ovf_raw_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res         = diff_s[WIDTH-1:0];
        carry_raw_s = diff_s[WIDTH];
        ovf_raw_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      OP_PASS: res = a;
      default: res = a;
    endcase
  end

  // Logic and unary opcodes never report carry or overflow.
  always_comb begin
    if (op_is_arith(op_s)) begin
      carry    = carry_raw_s;
      overflow = ovf_raw_s;
    end else begin
      carry    = 1'b0;
      overflow = 1'b0;
    end
  end

endmodule

// File: rtl/alu.sv
// Registered ALU stage: one-cycle latency, result and flags captured on
// in_valid, out_valid marks each fresh result for exactly one cycle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;
  alu_flags_t       flags_nxt_s;

  logic [WIDTH-1:0] out_r;
  alu_flags_t       flags_r;
  logic             valid_r;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a        (A),
    .b        (B),
    .sel      (sel),
    .res      (res_s),
    .carry    (carry_s),
    .overflow (ovf_s)
  );

  // zero/negative are taken from the value about to be registered, so they
  // always describe the registered out.
  always_comb begin
    flags_nxt_s          = FLAGS_RESET;
    flags_nxt_s.carry    = carry_s;
    flags_nxt_s.overflow = ovf_s;
    flags_nxt_s.zero     = (res_s == {WIDTH{1'b0}});
    flags_nxt_s.negative = res_s[WIDTH-1];
  end

  // Result, flag and valid registers; idle cycles hold result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r   <= {WIDTH{1'b0}};
      flags_r <= FLAGS_RESET;
      valid_r <= 1'b0;
    end else if (in_valid) begin
      out_r   <= res_s;
      flags_r <= flags_nxt_s;
      valid_r <= 1'b1;
    end else begin
      out_r   <= out_r;
      flags_r <= flags_r;
      valid_r <= 1'b0;
    end
  end

  assign out       = out_r;
  assign out_valid = valid_r;
  assign carry     = flags_r.carry;
  assign overflow  = flags_r.overflow;
  assign zero      = flags_r.zero;
  assign negative  = flags_r.negative;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (WIDTH = 4): directed vectors plus random
// traffic compared against an integer-arithmetic reference model.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] sel;
  logic [3:0] out;
  logic       out_valid;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       negative;

  int n_checks;
  int n_errors;

  // reference state
  int exp_out;
  int exp_valid;
  int exp_carry;
  int exp_ovf;

  alu #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_signed4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // Reference model from the arithmetic definition of each opcode.
  task automatic model(input logic v, input int a, input int b, input int s);
    int r;
    int sr;
    if (!v) begin
      exp_valid = 0;
    end else begin
      exp_valid = 1;
      exp_carry = 0;
      exp_ovf   = 0;
      case (s)
        0: begin
          r = a + b;
          sr = to_signed4(a) + to_signed4(b);
          exp_carry = (r > 15) ? 1 : 0;
          exp_ovf   = (sr > 7 || sr < -8) ? 1 : 0;
        end
        1: begin
          r = a - b;
          sr = to_signed4(a) - to_signed4(b);
          exp_carry = (a < b) ? 1 : 0;
          exp_ovf   = (sr > 7 || sr < -8) ? 1 : 0;
        end
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: r = ~(a ^ b);
        6: r = ~a;
        default: r = a;
      endcase
      exp_out = r & 15;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out"},       32'(out),       32'(exp_out));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    check({tag, ".carry"},     32'(carry),     32'(exp_carry));
    check({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
    check({tag, ".zero"},      32'(zero),      32'((exp_out == 0) ? 1 : 0));
    check({tag, ".negative"},  32'(negative),  32'((exp_out >= 8) ? 1 : 0));
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic [2:0] s);
    @(negedge clk);
    in_valid = v;
    A        = a;
    B        = b;
    sel      = s;
    model(v, int'(a), int'(b), int'(s));
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic model_reset();
    exp_out   = 0;
    exp_valid = 0;
    exp_carry = 0;
    exp_ovf   = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 4'd0;
    B        = 4'd0;
    sel      = 3'd0;
    model_reset();

    // Reset held with random valid traffic: nothing may be captured.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      A        = 4'($urandom_range(0, 15));
      B        = 4'($urandom_range(0, 15));
      sel      = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      compare_all("reset_hold");
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Directed vectors, issued back to back.
    step("add_neg",   1'b1, 4'b0001, 4'b1101, 3'b000);
    check("add_neg.out_const", 32'(out), 32'h0000000e);
    step("sub_borrow",1'b1, 4'b0001, 4'b1101, 3'b001);
    check("sub_borrow.out_const", 32'(out), 32'h00000004);
    step("sub_ovf",   1'b1, 4'b0111, 4'b1000, 3'b001);
    check("sub_ovf.ovf_const", 32'(overflow), 32'h00000001);
    step("and",       1'b1, 4'b0011, 4'b1001, 3'b010);
    step("or",        1'b1, 4'b0011, 4'b1100, 3'b011);
    step("xor",       1'b1, 4'b1001, 4'b1011, 3'b100);
    step("xnor",      1'b1, 4'b0001, 4'b1101, 3'b101);
    step("not_b0",    1'b1, 4'b1101, 4'b0000, 3'b110);
    step("not_b1",    1'b1, 4'b1101, 4'b1111, 3'b110);
    step("pass_b0",   1'b1, 4'b1101, 4'b0101, 3'b111);
    step("pass_b1",   1'b1, 4'b1101, 4'b1010, 3'b111);
    step("add_wrap",  1'b1, 4'b1111, 4'b0001, 3'b000);
    check("add_wrap.zero_const", 32'(zero), 32'h00000001);
    step("idle0",     1'b0, 4'b0110, 4'b0110, 3'b000);
    step("idle1",     1'b0, 4'b1010, 4'b0011, 3'b011);
    step("add_ovf",   1'b1, 4'b0111, 4'b0001, 3'b000);

    // Mid-stream reset must clear outputs before the next clock edge.
    step("pre_rst",   1'b1, 4'b0111, 4'b0110, 3'b011);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst",  1'b0, 4'b0101, 4'b0101, 3'b000);

    // Random traffic with random idle cycles.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
